trig_sequencer: RTL and testbench

- Initiator side of the sniffer's pattern-compare interface. Loads a programmed sequence of up to DEPTH pattern words into a downstream comparator one word at a time over the latch/enable/match handshake.
- Consumes the comparator's registered match pulse, advances stage by stage, and emits a one-cycle trigger when the full sequence has matched in order.
- Sits between the register/config interface and the comparator instance in the sniffer.

---
 rtl/trig_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_trig_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_sequencer.sv
// Pattern-sequence initiator: loads up to DEPTH words into a comparator and pulses
// trigger when every stage matches in order. Define TRIG_SEQ_TIMEOUT_EN for the inter-stage timeout.
module trig_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SW    = 2,
  parameter int TW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [SW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [SW-1:0]    last_stage,
  input  logic             arm,
  input  logic             rearm,
  input  logic [TW-1:0]    timeout,
  output logic [WIDTH-1:0] cmp_a,
  output logic             cmp_take,
  output logic             cmp_enable,
  input  logic             cmp_result,
  output logic             trigger,
  output logic             busy,
  output logic [SW-1:0]    stage,
  output logic             timed_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_TRIG = 2'd3
  } state_e;

  localparam logic [SW-1:0] STAGE_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0] STAGE_ONE  = {{(SW-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [WIDTH-1:0] cmp_a_q, cmp_a_d;
  logic             cmp_take_q, cmp_take_d;
  logic             cmp_enable_q, cmp_enable_d;
  logic             trigger_q, trigger_d;
  logic             busy_q, busy_d;
  logic             timed_out_q, timed_out_d;
  logic [WIDTH-1:0] pat_q [DEPTH];
  logic [WIDTH-1:0] pat_d [DEPTH];
  logic             expire_s;

`ifdef TRIG_SEQ_TIMEOUT_EN
  localparam logic [TW-1:0] CNT_ONE = {{(TW-1){1'b0}}, 1'b1};

  logic [TW-1:0] cnt_q, cnt_d;
  logic          cnt_run_s;

  // Only stages past the first are timed; a zero timeout disables the check.
  assign cnt_run_s = (state_q == S_WAIT) && (stage_q != STAGE_ZERO) && (timeout != {TW{1'b0}});
  assign expire_s  = cnt_run_s && (cnt_q >= (timeout - CNT_ONE));

  // Counter next value: count WAIT cycles, clear on any exit from WAIT.
  always_comb begin
    if (cnt_run_s && arm && !cmp_result && !expire_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = {TW{1'b0}};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {TW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_s;

  assign unused_timeout_s = ^timeout;
  assign expire_s         = 1'b0;
`endif

  // Pattern slot writes, accepted only while idle.
  always_comb begin
    pat_d = pat_q;
    if (cfg_we && (state_q == S_IDLE)) begin
      pat_d[cfg_addr] = cfg_data;
    end else begin
      pat_d[cfg_addr] = pat_q[cfg_addr];
    end
  end

  // Sequencer next state; abort beats match, match beats timeout.
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    timed_out_d = 1'b0;
    if (!arm) begin
      state_d = S_IDLE;
      stage_d = STAGE_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_LOAD;
          stage_d = STAGE_ZERO;
        end
        S_LOAD: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cmp_result && (stage_q >= last_stage)) begin
            state_d = S_TRIG;
            stage_d = STAGE_ZERO;
          end else if (cmp_result) begin
            state_d = S_LOAD;
            stage_d = stage_q + STAGE_ONE;
          end else if (expire_s) begin
            state_d     = S_LOAD;
            stage_d     = STAGE_ZERO;
            timed_out_d = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_TRIG: begin
          stage_d = STAGE_ZERO;
          if (rearm) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          stage_d = STAGE_ZERO;
        end
      endcase
    end
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    cmp_take_d   = (state_d == S_LOAD);
    cmp_enable_d = (state_d == S_WAIT);
    trigger_d    = (state_d == S_TRIG);
    busy_d       = (state_d != S_IDLE);
    if (state_d == S_LOAD) begin
      cmp_a_d = pat_q[stage_d];
    end else begin
      cmp_a_d = cmp_a_q;
    end
  end

  // State, output and pattern registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      stage_q      <= STAGE_ZERO;
      cmp_a_q      <= {WIDTH{1'b1}};
      cmp_take_q   <= 1'b0;
      cmp_enable_q <= 1'b0;
      trigger_q    <= 1'b0;
      busy_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i] <= {WIDTH{1'b1}};
      end
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      cmp_a_q      <= cmp_a_d;
      cmp_take_q   <= cmp_take_d;
      cmp_enable_q <= cmp_enable_d;
      trigger_q    <= trigger_d;
      busy_q       <= busy_d;
      timed_out_q  <= timed_out_d;
      pat_q        <= pat_d;
    end
  end

  assign cmp_a      = cmp_a_q;
  assign cmp_take   = cmp_take_q;
  assign cmp_enable = cmp_enable_q;
  assign trigger    = trigger_q;
  assign busy       = busy_q;
  assign stage      = stage_q;
  assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer with a behavioural registered comparator on the bus.
// Cycle numbers count ticks after arm is raised; cycle 1 is the first LOAD.
module tb_trig_sequencer;
  localparam int WIDTH = 32;
  localparam int SW    = 2;
  localparam int TW    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_we;
  logic [SW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic [SW-1:0]    last_stage;
  logic             arm;
  logic             rearm;
  logic [TW-1:0]    timeout;
  logic [WIDTH-1:0] cmp_a;
  logic             cmp_take;
  logic             cmp_enable;
  logic             cmp_result;
  logic             trigger;
  logic             busy;
  logic [SW-1:0]    stage;
  logic             timed_out;

  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] lat;
  logic [WIDTH-1:0] seq_w [4];
  int vectors;
  int miscompares;
  int cyc;

  trig_sequencer #(.WIDTH(WIDTH), .DEPTH(4), .SW(SW), .TW(TW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .last_stage(last_stage), .arm(arm), .rearm(rearm), .timeout(timeout),
    .cmp_a(cmp_a), .cmp_take(cmp_take), .cmp_enable(cmp_enable), .cmp_result(cmp_result),
    .trigger(trigger), .busy(busy), .stage(stage), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  // Downstream comparator: latch on take, registered match while enabled.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat        <= 32'hFFFF_FFFF;
      cmp_result <= 1'b0;
    end else begin
      if (cmp_take) lat <= cmp_a;
      cmp_result <= cmp_enable && (bus == lat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic write_slot(input logic [SW-1:0] a, input logic [WIDTH-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic setup_abcd();
    for (int i = 0; i < 4; i++) write_slot(SW'(i), seq_w[i]);
    last_stage = 2'd3; rearm = 1'b0; timeout = 16'd0; bus = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    vectors++;
    if (cmp_a !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL reset_cmp_a: got %h want %h", cmp_a, 32'hFFFF_FFFF);
    end
    vectors++;
    if ({cmp_take, cmp_enable, trigger, busy, stage, timed_out} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got take/en/trig/busy/stage/to=%b want 0000000",
               {cmp_take, cmp_enable, trigger, busy, stage, timed_out});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_sequence();
    int takes, trigs, trig_cyc;
    setup_abcd();
    arm = 1'b1; cyc = 0; takes = 0; trigs = 0; trig_cyc = -1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (cmp_take) begin
        if (takes < 4) begin
          vectors++;
          if (cmp_a !== seq_w[takes] || stage !== SW'(takes) || cyc !== 1 + 3 * takes) begin
            miscompares++;
            $display("FAIL seq_take%0d: got a=%h stage=%0d cyc=%0d want a=%h stage=%0d cyc=%0d",
                     takes, cmp_a, stage, cyc, seq_w[takes], takes, 1 + 3 * takes);
          end
          bus = seq_w[takes];
        end
        takes++;
      end
      if (trigger) begin trigs++; trig_cyc = cyc; end
    end
    vectors++;
    if (takes !== 4 || trigs !== 1 || trig_cyc !== 13) begin
      miscompares++;
      $display("FAIL seq_trigger: got takes=%0d trigs=%0d trig_cyc=%0d want 4 1 13", takes, trigs, trig_cyc);
    end
    vectors++;
    if (busy !== 1'b0 || cmp_enable !== 1'b0 || stage !== 2'd0) begin
      miscompares++;
      $display("FAIL seq_idle: got busy=%b en=%b stage=%0d want 0 0 0", busy, cmp_enable, stage);
    end
    arm = 1'b0;
    tick(); tick();
  endtask

  task automatic test_mismatch();
    int takes, trigs, tos;
    setup_abcd();
    arm = 1'b1; cyc = 0; takes = 0; trigs = 0; tos = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (cmp_take) begin
        bus = (takes == 0) ? 32'hA : 32'hC;
        takes++;
      end
      if (trigger) trigs++;
      if (timed_out) tos++;
    end
    vectors++;
    if (takes !== 2 || trigs !== 0 || tos !== 0) begin
      miscompares++;
      $display("FAIL mismatch_counts: got takes=%0d trigs=%0d tos=%0d want 2 0 0", takes, trigs, tos);
    end
    vectors++;
    if (stage !== 2'd1 || busy !== 1'b1 || cmp_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL mismatch_hold: got stage=%0d busy=%b en=%b want 1 1 1", stage, busy, cmp_enable);
    end
    arm = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int takes, tos, to_cyc, wait_cyc, to_take, to_stage;
    logic [WIDTH-1:0] to_a;
    setup_abcd();
    timeout = 16'd10;
    arm = 1'b1; cyc = 0; takes = 0; tos = 0; to_cyc = -1; wait_cyc = -1;
    to_take = 0; to_stage = -1; to_a = 32'h0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (cmp_take) begin
        if (takes == 0) bus = 32'hA;
        else bus = 32'h0;
        takes++;
      end
      if (wait_cyc < 0 && cmp_enable && stage == 2'd1) wait_cyc = cyc;
      if (timed_out) begin
        tos++; to_cyc = cyc; to_take = int'(cmp_take); to_a = cmp_a; to_stage = int'(stage);
      end
    end
    vectors++;
    if (wait_cyc !== 5) begin
      miscompares++; $display("FAIL to_wait_entry: got %0d want 5", wait_cyc);
    end
`ifdef TRIG_SEQ_TIMEOUT_EN
    vectors++;
    if (tos !== 1 || to_cyc - wait_cyc !== 10 || takes !== 3) begin
      miscompares++;
      $display("FAIL to_pulse: got tos=%0d delay=%0d takes=%0d want 1 10 3", tos, to_cyc - wait_cyc, takes);
    end
    vectors++;
    if (to_take !== 1 || to_a !== 32'hA || to_stage !== 0) begin
      miscompares++;
      $display("FAIL to_reload: got take=%0d a=%h stage=%0d want 1 0000000a 0", to_take, to_a, to_stage);
    end
`else
    vectors++;
    if (tos !== 0 || takes !== 2 || stage !== 2'd1) begin
      miscompares++;
      $display("FAIL to_disabled: got tos=%0d takes=%0d stage=%0d want 0 2 1", tos, takes, stage);
    end
`endif
    arm = 1'b0;
    tick(); tick();
    // Match result lands in the very cycle the counter would expire.
    arm = 1'b1; cyc = 0; takes = 0; tos = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (cmp_take) begin
        if (takes == 0) bus = 32'hA;
        else bus = 32'h0;
        takes++;
      end
      if (cyc == 13) bus = 32'hB;
      if (timed_out) tos++;
    end
    vectors++;
    if (tos !== 0 || cmp_take !== 1'b1 || cmp_a !== 32'hC || stage !== 2'd2) begin
      miscompares++;
      $display("FAIL to_match_wins: got tos=%0d take=%b a=%h stage=%0d want 0 1 0000000c 2",
               tos, cmp_take, cmp_a, stage);
    end
    arm = 1'b0; timeout = 16'd0;
    tick(); tick();
  endtask

  task automatic test_rearm();
    int takes, trigs, busy_low, last_take;
    write_slot(2'd0, 32'h55);
    last_stage = 2'd0; rearm = 1'b1; timeout = 16'd0; bus = 32'h55;
    arm = 1'b1; cyc = 0; takes = 0; trigs = 0; busy_low = 0; last_take = -100;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy !== 1'b1) busy_low++;
      if (cmp_take) begin takes++; last_take = cyc; end
      if (trigger) begin
        trigs++;
        vectors++;
        if (cyc - last_take !== 3 || cyc !== 4 * trigs) begin
          miscompares++;
          $display("FAIL rearm_spacing: got cyc=%0d since_load=%0d want cyc=%0d since_load=3",
                   cyc, cyc - last_take, 4 * trigs);
        end
      end
    end
    vectors++;
    if (trigs !== 5 || takes !== 5 || busy_low !== 0) begin
      miscompares++;
      $display("FAIL rearm_counts: got trigs=%0d takes=%0d busy_low=%0d want 5 5 0", trigs, takes, busy_low);
    end
    arm = 1'b0; rearm = 1'b0;
    tick(); tick();
  endtask

  task automatic test_abort();
    int takes, trigs;
    setup_abcd();
    arm = 1'b1; cyc = 0; takes = 0; trigs = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (cmp_take) begin bus = seq_w[takes]; takes++; end
      if (cyc == 5) begin cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 32'h99; end
      if (cyc == 6) cfg_we = 1'b0;
      if (trigger) trigs++;
    end
    vectors++;
    if (stage !== 2'd2 || cmp_enable !== 1'b1) begin
      miscompares++; $display("FAIL abort_pre: got stage=%0d en=%b want 2 1", stage, cmp_enable);
    end
    arm = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || cmp_enable !== 1'b0 || stage !== 2'd0 || trigger !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got busy=%b en=%b stage=%0d trig=%b want 0 0 0 0", busy, cmp_enable, stage, trigger);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (trigger) trigs++;
    end
    vectors++;
    if (trigs !== 0) begin
      miscompares++; $display("FAIL abort_no_trig: got %0d triggers want 0", trigs);
    end
    // Rerun to prove the busy-time write to slot 1 was dropped.
    bus = 32'h0; arm = 1'b1; cyc = 0; takes = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (cmp_take) begin
        if (takes == 1) begin
          vectors++;
          if (cmp_a !== 32'hB) begin
            miscompares++; $display("FAIL abort_slot1: got %h want 0000000b", cmp_a);
          end
        end
        if (takes < 4) bus = seq_w[takes];
        takes++;
      end
      if (trigger) trigs++;
    end
    vectors++;
    if (trigs !== 1) begin
      miscompares++; $display("FAIL abort_rerun_trig: got %0d want 1", trigs);
    end
    arm = 1'b0;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    setup_abcd();
    arm = 1'b1; cyc = 0;
    tick();
    bus = 32'hA;
    tick();
    vectors++;
    if (cmp_enable !== 1'b1 || cmp_a !== 32'hA) begin
      miscompares++; $display("FAIL areset_pre: got en=%b a=%h want 1 0000000a", cmp_enable, cmp_a);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (cmp_a !== 32'hFFFF_FFFF || {cmp_take, cmp_enable, trigger, busy, stage, timed_out} !== 7'b0) begin
      miscompares++;
      $display("FAIL areset_now: got a=%h ctrl=%b want ffffffff 0000000", cmp_a,
               {cmp_take, cmp_enable, trigger, busy, stage, timed_out});
    end
    arm = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    arm = 1'b1; cyc = 0;
    tick();
    vectors++;
    if (cmp_take !== 1'b1 || cmp_a !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL areset_slots: got take=%b a=%h want 1 ffffffff", cmp_take, cmp_a);
    end
    arm = 1'b0;
    tick(); tick();
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    seq_w[0] = 32'hA; seq_w[1] = 32'hB; seq_w[2] = 32'hC; seq_w[3] = 32'hD;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 32'h0;
    last_stage = 2'd0; arm = 1'b0; rearm = 1'b0; timeout = 16'd0; bus = 32'h0;
    #2;
    test_reset();
    test_sequence();
    test_mismatch();
    test_timeout();
    test_rearm();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
